// File: rtl/prog_memory_pkg.sv
// Shared CPU definitions used by the program memory: default widths, the NOP
// opcode, the loader FSM state type and an even-parity helper.
package cpu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] OPC_NOP = 8'h00;

  typedef enum logic [1:0] {
    PM_IDLE,
    PM_LOAD,
    PM_DONE
  } pm_state_t;

  // Returns the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W_DEF-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/prog_memory_if.sv
// Fetch and loader signals of the program memory. parity_err exists only when
// PROG_MEMORY_PARITY_EN is defined.
interface prog_memory_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              fetch_en;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_valid;
   logic              load_start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              busy;
   logic              load_done;
`ifdef PROG_MEMORY_PARITY_EN
   logic              parity_err;

   modport master (
      output fetch_en, fetch_addr, load_start, load_valid, load_data,
      input  fetch_data, fetch_valid, load_ready, busy, load_done, parity_err
   );
   modport slave (
      input  fetch_en, fetch_addr, load_start, load_valid, load_data,
      output fetch_data, fetch_valid, load_ready, busy, load_done, parity_err
   );
`else
   modport master (
      output fetch_en, fetch_addr, load_start, load_valid, load_data,
      input  fetch_data, fetch_valid, load_ready, busy, load_done
   );
   modport slave (
      input  fetch_en, fetch_addr, load_start, load_valid, load_data,
      output fetch_data, fetch_valid, load_ready, busy, load_done
   );
`endif
endinterface

// File: rtl/prog_mem_array.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents power up as all-zero words (NOP, with correct even parity).
module prog_mem_array #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   // NOTE: the storage array is never reset, so it maps onto block RAM; it only
   // carries a power-up value.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register holds its value between fetches; only it is cleared on reset.
   always_ff @(posedge clk) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/prog_memory.sv
// Loadable program memory: loader FSM, write pointer, fetch range check and,
// when PROG_MEMORY_PARITY_EN is defined, per-word even parity with parity_err.
module prog_memory
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input logic          clk,
   input logic          rst_n,
   prog_memory_if.slave bus
);
`ifdef PROG_MEMORY_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   // One spare bit so the pointer can count to DEPTH when DEPTH == 2**ADDR_W.
   localparam int PTR_W = ADDR_W + 1;

   pm_state_t         state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr;
   logic              beat, last_beat, fetch_ok, in_range, rd_en;
   logic              fetch_valid_q, oor_q;
   logic [MEM_W-1:0]  wdata, rdata;
   logic              busy_c, ready_c, done_c;

   // A beat offered together with load_start is dropped by the restart.
   assign beat      = (state_q == PM_LOAD) && bus.load_valid && !bus.load_start;
   assign last_beat = beat && (wr_ptr == PTR_W'(DEPTH - 1));
   assign fetch_ok  = bus.fetch_en && (state_q != PM_LOAD);
   assign in_range  = {1'b0, bus.fetch_addr} < PTR_W'(DEPTH);
   assign rd_en     = fetch_ok && in_range;

   // NOTE: sequential state is written with <= only, so every register samples
   // the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= PM_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: each combinational output gets a default first, so no latch forms.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PM_IDLE: if (bus.load_start) state_d = PM_LOAD;
         PM_LOAD: if (last_beat)      state_d = PM_DONE;
         PM_DONE:                     state_d = PM_IDLE;
         default:                     state_d = PM_IDLE;
      endcase
   end

   always_comb begin
      busy_c  = 1'b0;
      ready_c = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         PM_LOAD: begin
            busy_c  = 1'b1;
            ready_c = 1'b1;
         end
         PM_DONE: done_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                 wr_ptr <= '0;
      else if (state_q != PM_LOAD || bus.load_start) wr_ptr <= '0;
      else if (beat)                              wr_ptr <= wr_ptr + 1'b1;
   end

   // oor_q remembers that the last accepted fetch was out of range so the
   // held read data is replaced by NOP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_valid_q <= 1'b0;
         oor_q         <= 1'b0;
      end else begin
         fetch_valid_q <= fetch_ok;
         if (fetch_ok) oor_q <= !in_range;
      end
   end

`ifdef PROG_MEMORY_PARITY_EN
   assign wdata = {even_parity(bus.load_data), bus.load_data};
`else
   assign wdata = bus.load_data;
`endif

   prog_mem_array #(
      .ADDR_W(ADDR_W),
      .DATA_W(MEM_W),
      .DEPTH (DEPTH)
   ) u_array (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (beat && rst_n),
      .waddr(wr_ptr[ADDR_W-1:0]),
      .wdata(wdata),
      .re   (rd_en),
      .raddr(bus.fetch_addr),
      .rdata(rdata)
   );

   assign bus.fetch_data  = oor_q ? DATA_W'(OPC_NOP) : rdata[DATA_W-1:0];
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.busy        = busy_c;
   assign bus.load_ready  = ready_c;
   assign bus.load_done   = done_c;
`ifdef PROG_MEMORY_PARITY_EN
   assign bus.parity_err  = fetch_valid_q && !oor_q && (^rdata);
`endif
endmodule

// File: tb/tb_prog_memory.sv
// Directed bench for prog_memory: a 16-word instance with a fetch scoreboard and
// a 12-word instance for range and (PROG_MEMORY_PARITY_EN) parity checks.
module tb_prog_memory;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prog_memory_if #(.ADDR_W(4), .DATA_W(8)) bus_a ();
   prog_memory_if #(.ADDR_W(4), .DATA_W(8)) bus_b ();

   prog_memory #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   prog_memory #(.ADDR_W(4), .DATA_W(8), .DEPTH(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   typedef struct {
      string      tag;
      logic       v;
      logic [7:0] d;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_d;
   logic [7:0] model [16];
   logic [7:0] prog  [16] = '{8'hA6, 8'hAF, 8'hB4, 8'hBD, 8'h10, 8'h31, 8'h41, 8'h61,
                              8'h88, 8'hF8, 8'hCB, 8'h9B, 8'hA7, 8'h7B, 8'h00, 8'h00};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Advance one clock, then compare the fetch result queued for that cycle.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.tag, ".valid"}, 32'(bus_a.fetch_valid), 32'(e.v));
         check({e.tag, ".data"},  32'(bus_a.fetch_data),  32'(e.d));
`ifdef PROG_MEMORY_PARITY_EN
         if (e.v) check({e.tag, ".perr"}, 32'(bus_a.parity_err), 32'd0);
`endif
      end
   endtask

   // Drive a fetch on instance A and queue what it must return next cycle.
   task automatic fetch_req(input logic en, input logic [3:0] addr, input logic allowed,
                            input string tag);
      exp_t e;
      bus_a.fetch_en   = en;
      bus_a.fetch_addr = addr;
      e.tag = tag;
      e.v   = en && allowed;
      if (e.v) last_d = model[addr];
      e.d   = last_d;
      exp_q.push_back(e);
   endtask

   task automatic readback(input string tag);
      for (int i = 0; i < 16; i++) begin
         fetch_req(1'b1, 4'(i), 1'b1, $sformatf("%s_%0d", tag, i));
         tick();
      end
      bus_a.fetch_en = 1'b0;
   endtask

   initial begin
      int n;
      int cyc;
      int done_cnt;
      logic v;

      rst_n = 1'b0;
      bus_a.fetch_en = 0; bus_a.fetch_addr = 0; bus_a.load_start = 0;
      bus_a.load_valid = 0; bus_a.load_data = 0;
      bus_b.fetch_en = 0; bus_b.fetch_addr = 0; bus_b.load_start = 0;
      bus_b.load_valid = 0; bus_b.load_data = 0;
      last_d = 8'h00;
      for (int i = 0; i < 16; i++) model[i] = OPC_NOP;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus_a.fetch_valid), 0);
      check("rst_data",  32'(bus_a.fetch_data), 0);
      check("rst_busy",  32'(bus_a.busy), 0);
      check("rst_ready", 32'(bus_a.load_ready), 0);
      check("rst_done",  32'(bus_a.load_done), 0);
      check("rst_b_busy", 32'(bus_b.busy), 0);
      rst_n = 1'b1;

      // Power-up contents are NOP; no request means no valid.
      fetch_req(1'b1, 4'd5, 1'b1, "nop_fetch");  tick();
      fetch_req(1'b0, 4'd0, 1'b1, "no_fetch");   tick();

      // Load 1: load_valid held high for 16 beats.
      bus_a.load_start = 1'b1; tick(); bus_a.load_start = 1'b0;
      check("ld1_busy",  32'(bus_a.busy), 1);
      check("ld1_ready", 32'(bus_a.load_ready), 1);
      for (int i = 0; i < 16; i++) begin
         bus_a.load_valid = 1'b1;
         bus_a.load_data  = prog[i];
         tick();
         check($sformatf("ld1_done_%0d", i), 32'(bus_a.load_done), 32'(i == 15));
      end
      bus_a.load_valid = 1'b0;
      check("ld1_busy_end", 32'(bus_a.busy), 0);
      for (int i = 0; i < 16; i++) model[i] = prog[i];
      // In DONE: fetch is served and load_start is ignored.
      bus_a.load_start = 1'b1;
      fetch_req(1'b1, 4'd0, 1'b1, "done_fetch");
      tick();
      bus_a.load_start = 1'b0;
      bus_a.fetch_en   = 1'b0;
      check("done_start_ignored", 32'(bus_a.busy), 0);
      check("done_pulse_once",    32'(bus_a.load_done), 0);
      readback("rd1");

      // Load 2: random load_valid gaps with a fetch attempt every cycle.
      bus_a.load_start = 1'b1; tick(); bus_a.load_start = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 16 && cyc < 300) begin
         v = (cyc % 5 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         bus_a.load_valid = v;
         bus_a.load_data  = v ? (prog[n] ^ 8'h5A) : 8'hC3;
         fetch_req(1'b1, 4'(n), 1'b0, "ld2_fetch");
         tick();
         if (v) n++;
         cyc++;
         check("ld2_busy",  32'(bus_a.busy), 32'(n < 16));
         check("ld2_ready", 32'(bus_a.load_ready), 32'(n < 16));
         check("ld2_done",  32'(bus_a.load_done), 32'(n == 16));
      end
      check("ld2_beats", 32'(n), 32'd16);
      bus_a.load_valid = 1'b0;
      bus_a.fetch_en   = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = prog[i] ^ 8'h5A;
      tick();
      readback("rd2");

      // Restart after 7 beats; the beat offered with the restart is dropped.
      bus_a.load_start = 1'b1; tick(); bus_a.load_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus_a.load_valid = 1'b1; bus_a.load_data = 8'h33; tick();
      end
      bus_a.load_start = 1'b1; bus_a.load_data = 8'h77; tick();
      bus_a.load_start = 1'b0;
      check("rst_ld_busy", 32'(bus_a.busy), 1);
      done_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         bus_a.load_data = 8'h55;
         tick();
         if (bus_a.load_done) done_cnt++;
         check($sformatf("rst_ld_done_%0d", i), 32'(bus_a.load_done), 32'(i == 15));
      end
      bus_a.load_valid = 1'b0;
      tick();
      if (bus_a.load_done) done_cnt++;
      check("rst_ld_done_once", 32'(done_cnt), 1);
      for (int i = 0; i < 16; i++) model[i] = 8'h55;
      readback("rd3");

      // Reset after 5 beats of EE: those stay, the rest keep 0x55.
      bus_a.load_start = 1'b1; tick(); bus_a.load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus_a.load_valid = 1'b1; bus_a.load_data = 8'hEE; tick();
      end
      bus_a.load_valid = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("midrst_busy",  32'(bus_a.busy), 0);
      check("midrst_ready", 32'(bus_a.load_ready), 0);
      check("midrst_data",  32'(bus_a.fetch_data), 0);
      last_d = 8'h00;
      for (int i = 0; i < 5; i++) model[i] = 8'hEE;
      // load_valid while IDLE must not write anything.
      bus_a.load_valid = 1'b1; bus_a.load_data = 8'h99; tick();
      bus_a.load_valid = 1'b0;
      readback("rd4");

      // DEPTH=12 instance: out-of-range fetch and a 12-beat load.
      bus_b.fetch_en = 1'b1; bus_b.fetch_addr = 4'd13; tick();
      bus_b.fetch_en = 1'b0;
      check("b_oor_valid", 32'(bus_b.fetch_valid), 1);
      check("b_oor_data",  32'(bus_b.fetch_data), 0);
      bus_b.load_start = 1'b1; tick(); bus_b.load_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus_b.load_valid = 1'b1; bus_b.load_data = 8'h10 + 8'(i); tick();
         check($sformatf("b_done_%0d", i), 32'(bus_b.load_done), 32'(i == 11));
      end
      bus_b.load_valid = 1'b0;
      tick();
      bus_b.fetch_en = 1'b1; bus_b.fetch_addr = 4'd11; tick();
      check("b_rd11_valid", 32'(bus_b.fetch_valid), 1);
      check("b_rd11_data",  32'(bus_b.fetch_data), 32'h1B);
      bus_b.fetch_addr = 4'd13; tick();
      check("b_oor2_data",  32'(bus_b.fetch_data), 0);
      bus_b.fetch_addr = 4'd2; tick();
      bus_b.fetch_en = 1'b0;
      check("b_rd2_data",   32'(bus_b.fetch_data), 32'h12);
`ifdef PROG_MEMORY_PARITY_EN
      check("b_rd2_perr",   32'(bus_b.parity_err), 0);
      dut_b.u_array.mem[2] <= dut_b.u_array.mem[2] ^ 9'h001;
      tick();
      bus_b.fetch_en = 1'b1; bus_b.fetch_addr = 4'd2; tick();
      check("b_flip_perr",  32'(bus_b.parity_err), 1);
      bus_b.fetch_addr = 4'd3; tick();
      bus_b.fetch_en = 1'b0;
      check("b_clean_perr", 32'(bus_b.parity_err), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/prog_memory.md
Name: prog_memory

Overview:
Parametrised, loadable successor to the fixed 16x8 instruction ROM. It holds DEPTH words of DATA_W bits and serves CPU instruction fetches through a registered read port with one cycle of latency. A valid/ready byte-stream loader lets the testbench or a boot controller write a program at runtime. Fetches are blocked while a load is in progress. The block sits between the program counter and the decoder.

Parameters:
ADDR_W, 4, fetch/load address width
DATA_W, 8, instruction word width
DEPTH, 1<<ADDR_W, number of words; must be <= 2**ADDR_W and >= 2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
fetch_en  in  1  fetch request this cycle
fetch_addr  in  ADDR_W  word address from PC
fetch_data  out  DATA_W  registered instruction word
fetch_valid  out  1  fetch_data is valid this cycle
load_start  in  1  pulse: begin a new program load at address 0
load_valid  in  1  load_data is offered
load_data  in  DATA_W  program word
load_ready  out  1  block accepts load_data this cycle
busy  out  1  load in progress, so fetches are ignored
load_done  out  1  one-cycle pulse after the last word is written

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, wr_ptr=0, fetch_data=0, fetch_valid=0, load_ready=0, busy=0, load_done=0. The array contents are NOT cleared by reset; they are initialised once to all 0x00 (NOP).
- FSM states:
  - IDLE: fetch allowed; load_ready=0. load_start moves to LOAD with wr_ptr=0.
  - LOAD: busy=1, load_ready=1. Each cycle with load_valid&&load_ready writes mem[wr_ptr]=load_data and increments wr_ptr. The write at wr_ptr==DEPTH-1 moves to DONE.
  - DONE: load_done=1 for one cycle, busy=0, load_ready=0, wr_ptr returns to 0, next state IDLE.
- Fetch: in IDLE or DONE, fetch_en at cycle N gives fetch_data=mem[fetch_addr] and fetch_valid=1 at N+1.
  - Without fetch_en, fetch_valid=0 at N+1 and fetch_data holds its last value.
  - fetch_addr >= DEPTH returns 0x00 (NOP) with fetch_valid=1.
- Fetch during LOAD: ignored, fetch_valid=0 the next cycle, and the request is not queued.
- load_start while already in LOAD restarts the load: wr_ptr=0, and any beat offered in that same cycle is dropped. load_start in DONE is ignored.
- load_valid outside LOAD: no write, no effect.
- Read/write same cycle: cannot occur, because fetches are blocked while loading.
- Reset mid-load: FSM returns to IDLE. Words already written are retained; the rest keep their old values.
- wr_ptr is ADDR_W+1 bits internally to avoid overflow when DEPTH == 2**ADDR_W.

Optional Feature:
PROG_MEMORY_PARITY_EN
- With the macro defined:
  - each word stores an extra even-parity bit, computed on load.
  - new output parity_err (1 bit) is registered alongside fetch_data and asserts with fetch_valid when the stored word's parity mismatches.
  - parity_err resets to 0.
  - initial NOP words carry correct parity.
- Without the macro: no parity storage and no parity_err port.

Decomposition:
- Shared package cpu_pkg:
  - constants ADDR_W_DEF=4, DATA_W_DEF=8, OPC_NOP=8'h00.
  - enum typedef pm_state_t {PM_IDLE, PM_LOAD, PM_DONE}.
- Sub-module prog_mem_array: simple dual-port synchronous RAM.
  - one write port, one registered read port.
  - parametrised by ADDR_W, DATA_W (+1 when parity is enabled), DEPTH.
- prog_memory holds the FSM, pointer, range check and parity logic.

Test Plan:
- Reset, then fetch_en at addr 5 → next cycle fetch_valid=1, fetch_data=0x00. With no fetch_en, fetch_valid=0.
- load_start, then stream A6,AF,B4,BD,10,31,41,61,88,F8,CB,9B,A7,7B,00,00 with load_valid held high → 16 writes, load_done pulses one cycle after the 16th beat. Fetch addr 0..15 returns the same words, each one cycle after request.
- During the load, toggle load_valid 1/0 randomly and assert fetch_en every cycle → busy=1, load_ready=1, fetch_valid=0 throughout. Only valid beats are written, and the words land in order.
- After 7 beats assert load_start again, then stream 16 beats of 0x55 → all 16 locations read 0x55. load_done pulses exactly once.
- Assert rst_n=0 after 5 beats of 0xEE over a loaded program → IDLE, busy=0. Addr 0..4 read 0xEE and addr 5..15 keep their old values.
- DEPTH=12, ADDR_W=4: fetch addr 13 → fetch_data=0x00, fetch_valid=1. A load completes after 12 beats. With PROG_MEMORY_PARITY_EN defined, force-flip one stored bit → parity_err=1 on the fetch of that word.
